// File: rtl/row_feed_pkg.sv
// row_feed_pkg: shared types and default parameter values for row_feed_buf.
//   state_t      - stream controller states
//   DEF_*        - default parameter values used by row_feed_buf and row_fifo
package row_feed_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_WORDLEN = 8;
   localparam int DEF_ROWS    = 4;
   localparam int DEF_DEPTH   = 8;
   localparam int DEF_LENW    = 8;

endpackage

// File: rtl/row_fifo.sv
// row_fifo: single-row circular FIFO with occupancy count.
//   clk, rst        - clock, synchronous active-high reset
//   flush           - empties the FIFO at the next edge (pointers and count to 0)
//   wr_en, wr_dat   - push one word; caller guarantees !full
//   rd_en, rd_dat   - pop one word; rd_dat shows the head word combinationally,
//                     caller guarantees !empty
//   full, empty     - derived from the registered count only
module row_fifo
   import row_feed_pkg::*;
#(
   parameter int WORDLEN = DEF_WORDLEN,
   parameter int DEPTH   = DEF_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               wr_en,
   input  logic [WORDLEN-1:0] wr_dat,
   input  logic               rd_en,
   output logic [WORDLEN-1:0] rd_dat,
   output logic               full,
   output logic               empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Storage carries no reset; only pointers and count define validity.
   logic [WORDLEN-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap.
         if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !flush) mem[wr_ptr_q] <= wr_dat;
   end

   assign rd_dat = mem[rd_ptr_q];
   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);

endmodule

// File: rtl/row_feed_buf.sv
// row_feed_buf: per-row input FIFOs feeding a systolic array with skewed lanes.
//   clk, rst                   - clock, synchronous active-high reset
//   in_valid/in_ready/in_row/in_dat - write port into the selected row FIFO
//   start, stream_len          - begin a stream of stream_len vector pops (IDLE only)
//   flush                      - discard all buffered words and abort any stream
//   out_valid[r], out_dat lane r - lane r output, delayed r cycles behind lane 0
//   full, empty                - per-row FIFO status
//   busy, done                 - controller not idle / one-cycle completion pulse
//   dbg_state                  - current controller state
//
// Handshake: a word is transferred on a rising edge where in_valid && in_ready;
// in_ready depends only on registered full state and flush, never on in_valid,
// and a write does not wait for in_ready to be seen first.
module row_feed_buf
   import row_feed_pkg::*;
#(
   parameter int WORDLEN = DEF_WORDLEN,
   parameter int ROWS    = DEF_ROWS,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int LENW    = DEF_LENW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [$clog2(ROWS)-1:0] in_row,
   input  logic [WORDLEN-1:0]      in_dat,
   input  logic                    start,
   input  logic [LENW-1:0]         stream_len,
   input  logic                    flush,
   output logic [ROWS-1:0]         out_valid,
   output logic [ROWS*WORDLEN-1:0] out_dat,
   output logic [ROWS-1:0]         full,
   output logic [ROWS-1:0]         empty,
   output logic                    busy,
   output logic                    done,
   output state_t                  dbg_state
);

   localparam int RW = $clog2(ROWS);
   localparam int DW = $clog2(ROWS + 1);

   state_t            state_q, state_d;
   logic [LENW-1:0]   remaining_q, remaining_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic              pop;
   logic              row_full;
   logic [ROWS-1:0]   wr_en;
   logic [WORDLEN-1:0] fifo_rd_dat [ROWS];

   // Unmatched row codes read as not-full; they never enable a write.
   always_comb begin
      row_full = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         if (in_row == RW'(r)) row_full = full[r];
      end
   end

   assign in_ready = !row_full && !flush;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign wr_en[r] = in_valid && in_ready && (in_row == RW'(r));

      row_fifo #(
         .WORDLEN (WORDLEN),
         .DEPTH   (DEPTH)
      ) u_fifo (
         .clk    (clk),
         .rst    (rst),
         .flush  (flush),
         .wr_en  (wr_en[r]),
         .wr_dat (in_dat),
         .rd_en  (pop),
         .rd_dat (fifo_rd_dat[r]),
         .full   (full[r]),
         .empty  (empty[r])
      );
   end

   // Controller: a pop happens only when every row holds a word, so all
   // lanes always advance together. DRAIN lets the deepest skew lane empty.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      drain_d     = drain_q;
      pop         = 1'b0;
      done        = 1'b0;
      if (flush) begin
         state_d     = ST_IDLE;
         remaining_d = '0;
         drain_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (stream_len == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d     = ST_STREAM;
                     remaining_d = stream_len;
                  end
               end
            end
            ST_STREAM: begin
               if (empty == '0) begin
                  pop         = 1'b1;
                  remaining_d = remaining_q - LENW'(1);
                  if (remaining_q == LENW'(1)) begin
                     state_d = ST_DRAIN;
                     drain_d = DW'(ROWS - 1);
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_q == '0) state_d = ST_DONE;
               else               drain_d = drain_q - DW'(1);
            end
            ST_DONE: begin
               done    = !rst;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         drain_q     <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         drain_q     <= drain_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

   // Lane r: stage 0 registers the popped word, stages 1..r add the skew.
   // All stages shift every cycle; a stall inserts a zero bubble.
   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [r:0]         v_q, v_d;
      logic [WORDLEN-1:0] dat_q [r+1];
      logic [WORDLEN-1:0] dat_d [r+1];

      always_comb begin
         v_d = '0;
         for (int k = 0; k <= r; k++) dat_d[k] = '0;
         if (!flush) begin
            v_d[0]   = pop;
            dat_d[0] = pop ? fifo_rd_dat[r] : '0;
            for (int k = 1; k <= r; k++) begin
               v_d[k]   = v_q[k-1];
               dat_d[k] = dat_q[k-1];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= '0;
            for (int k = 0; k <= r; k++) dat_q[k] <= '0;
         end else begin
            v_q   <= v_d;
            dat_q <= dat_d;
         end
      end

      assign out_valid[r]                     = v_q[r];
      assign out_dat[r*WORDLEN +: WORDLEN]    = dat_q[r];
   end

endmodule
